// File: rtl/spi_slave_byte.sv
// spi_slave_byte: SPI mode-0 byte responder, oversampled in the clk_i domain.
// Full-duplex MSB-first shifting with a one-deep transmit holding register.
module spi_slave_byte #(
  parameter logic [7:0] DEFAULT_TX  = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_n_i,
  input  logic       sck_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q, primed_q;
  logic                   cs_dly_q, sck_dly_q;
  logic                   armed_q, armed_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic [7:0]             hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;
  logic                   load, accept;
  logic [7:0]             load_byte;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_dly_q & ~cs_s;
  assign cs_rise  = ~cs_dly_q & cs_s;
  assign sck_rise = ~sck_dly_q & sck_s;
  assign sck_fall = sck_dly_q & ~sck_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      primed_q    <= '0;
      cs_dly_q    <= 1'b1;
      sck_dly_q   <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      primed_q    <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      cs_dly_q    <= cs_s;
      sck_dly_q   <= sck_s;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  // cs only arms once the sync chain holds real pin samples, not its reset value
  always_comb begin
    armed_d    = armed_q | (primed_q[SYNC_STAGES-1] & cs_s);
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    load       = 1'b0;
    load_byte  = hold_full_q ? hold_q : DEFAULT_TX;
    if (state_q == IDLE) begin
      if (cs_fall && armed_q) begin
        state_d    = SHIFT;
        bit_cnt_d  = '0;
        load       = 1'b1;
        tx_shift_d = load_byte;
      end
    end else if (cs_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (sck_rise) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      rx_valid_d = bit_cnt_q == 3'd7;
      rx_data_d  = bit_cnt_q == 3'd7 ? rx_shift_d : rx_data_q;
    end else if (sck_fall) begin
      load       = bit_cnt_q == 3'd0;
      tx_shift_d = bit_cnt_q == 3'd0 ? load_byte : {tx_shift_q[6:0], 1'b0};
    end
    accept      = tx_valid_i & ~hold_full_q;
    hold_d      = accept ? tx_data_i : hold_q;
    hold_full_d = accept | (hold_full_q & ~load);
    underrun_d  = load & ~hold_full_q;
  end

  assign busy_o        = state_q == SHIFT;
  assign miso_oe_o     = busy_o;
  assign miso_o        = busy_o & tx_shift_q[7];
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = ~hold_full_q;
  assign tx_underrun_o = underrun_q;
endmodule

// File: tb/tb_spi_slave_byte.sv
// tb_spi_slave_byte: drives SPI mode-0 frames into spi_slave_byte and compares
// miso/rx/underrun behaviour against a byte-queue model of the transmit path.
module tb_spi_slave_byte;
  localparam int SYNC = 2;
  localparam int H    = 8;

  logic       clk = 1'b0;
  logic       rst, cs_n, sck, mosi;
  logic       miso, miso_oe, rx_valid, tx_valid, tx_ready, und, busy;
  logic [7:0] rx_data, tx_data;

  always #5 clk = ~clk;

  spi_slave_byte dut (
    .clk_i(clk), .rst_i(rst), .cs_n_i(cs_n), .sck_i(sck), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .tx_underrun_o(und), .busy_o(busy)
  );

  int         vectors = 0, miscompares = 0;
  int         und_cnt = 0, busy_cycles = 0;
  logic [7:0] txq[$], mq[$], rxq[$];

  typedef struct {
    int          n_off;
    logic [7:0]  off0, off1;
    int          nbits;
    logic [31:0] mosi_v, exp_miso;
    int          exp_rx, exp_und;
  } vec_t;
  vec_t tbl[5];

  always @(negedge clk) begin
    if (rx_valid) rxq.push_back(rx_data);
    if (und) und_cnt++;
    if (busy) busy_cycles++;
  end

  // offers queued bytes on tx_valid/tx_data, dropping each once it is accepted
  initial begin
    logic [7:0] dropped;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(posedge clk);
      if (tx_valid && tx_ready) dropped = txq.pop_front();
      @(negedge clk);
      tx_valid = txq.size() != 0;
      tx_data  = tx_valid ? txq[0] : 8'h00;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic sck_pulse(input logic b);
    mosi = b;
    repeat (H) @(negedge clk);
    sck = 1'b1;
    repeat (H) @(negedge clk);
    sck = 1'b0;
  endtask

  // the last sck fall coincides with cs rise so no trailing byte-boundary reload occurs
  task automatic run_frame(input int nbits, input logic [31:0] mv, output logic [31:0] sv);
    sv = '0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (2*H) @(negedge clk);
    for (int i = nbits-1; i >= 0; i--) begin
      mosi = mv[i];
      repeat (H) @(negedge clk);
      sv  = {sv[30:0], miso};
      sck = 1'b1;
      repeat (H) @(negedge clk);
      sck = 1'b0;
      if (i == 0) cs_n = 1'b1;
    end
    repeat (SYNC) @(negedge clk);
    check("busy_before_cs_latency", busy, 1);
    repeat (2) @(negedge clk);
    check("idle_after_cs_rise", {busy, miso_oe, miso}, 0);
    repeat (2*H) @(negedge clk);
  endtask

  task automatic model_frame(input int nbits, input logic [31:0] mv);
    int          loads, ue, u0;
    logic [31:0] st, sv;
    loads = (nbits + 7) / 8;
    ue    = 0;
    st    = '0;
    for (int j = 0; j < loads; j++) begin
      if (mq.size() > 0) st = {st[23:0], mq.pop_front()};
      else begin
        st = {st[23:0], 8'hFF};
        ue++;
      end
    end
    rxq.delete();
    u0 = und_cnt;
    run_frame(nbits, mv, sv);
    check("model_miso", sv, st >> (8*loads - nbits));
    check("model_rx_count", rxq.size(), nbits / 8);
    for (int k = 0; k < nbits / 8 && k < rxq.size(); k++)
      check("model_rx_data", rxq[k], (mv >> (nbits - 8*(k+1))) & 32'hFF);
    check("model_underrun", und_cnt - u0, ue);
  endtask

  initial begin
    logic [31:0] sv;
    int          u0;
    logic [7:0]  b;
    tbl[0] = '{1, 8'hA5, 8'h00, 8,  32'h3C,   32'hA5,   1, 0};
    tbl[1] = '{2, 8'h11, 8'h22, 16, 32'hF00F, 32'h1122, 2, 0};
    tbl[2] = '{0, 8'h00, 8'h00, 16, 32'h1234, 32'hFFFF, 2, 2};
    tbl[3] = '{0, 8'h00, 8'h00, 5,  32'h15,   32'h1F,   0, 1};
    tbl[4] = '{0, 8'h00, 8'h00, 8,  32'h81,   32'hFF,   1, 1};
    rst = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    #2 rst = 1'b1;
    #2 check("reset_outputs", {miso, miso_oe, busy, rx_valid, und, tx_ready, rx_data},
                              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < tbl[r].n_off; k++) txq.push_back(k == 0 ? tbl[r].off0 : tbl[r].off1);
      repeat (4) @(negedge clk);
      check("ready_after_offer", tx_ready, tbl[r].n_off == 0);
      rxq.delete();
      u0 = und_cnt;
      run_frame(tbl[r].nbits, tbl[r].mosi_v, sv);
      check("tbl_miso", sv, tbl[r].exp_miso);
      check("tbl_rx_count", rxq.size(), tbl[r].exp_rx);
      for (int k = 0; k < tbl[r].exp_rx && k < rxq.size(); k++)
        check("tbl_rx_data", rxq[k], (tbl[r].mosi_v >> (tbl[r].nbits - 8*(k+1))) & 32'hFF);
      check("tbl_underrun", und_cnt - u0, tbl[r].exp_und);
      check("tbl_ready_idle", tx_ready, 1);
    end

    for (int n = 0; n < 20; n++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        b = 8'($urandom);
        txq.push_back(b);
        mq.push_back(b);
      end
      repeat (10) @(negedge clk);
      model_frame($urandom_range(1, 24), $urandom);
    end
    while (mq.size() > 0) model_frame(8, $urandom);

    // cs already low when reset releases: the frame in progress must be ignored
    @(negedge clk);
    rst  = 1'b1;
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    busy_cycles = 0;
    rxq.delete();
    repeat (2*H) @(negedge clk);
    for (int k = 0; k < 8; k++) sck_pulse(1'($urandom));
    repeat (4) @(negedge clk);
    check("locked_busy_cycles", busy_cycles, 0);
    check("locked_rx_count", rxq.size(), 0);
    cs_n = 1'b1;
    repeat (2*H) @(negedge clk);
    model_frame(8, 32'h5A);
    check("relock_rx_data", rx_data, 8'h5A);

    // reset asserted during the 4th sck high phase of a byte
    txq.push_back(8'hC3);
    txq.push_back(8'h3C);
    repeat (6) @(negedge clk);
    cs_n = 1'b0;
    repeat (2*H) @(negedge clk);
    for (int k = 0; k < 3; k++) sck_pulse(1'b1);
    mosi = 1'b1;
    repeat (H) @(negedge clk);
    sck = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_reset_busy_full", {busy, tx_ready}, 2'b10);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {miso, miso_oe, busy, rx_valid, und, tx_ready, rx_data},
                                    {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    busy_cycles = 0;
    rxq.delete();
    repeat (H) @(negedge clk);
    sck = 1'b0;
    for (int k = 0; k < 4; k++) sck_pulse(1'b0);
    repeat (4) @(negedge clk);
    check("no_resume_busy_cycles", busy_cycles, 0);
    check("no_resume_rx_count", rxq.size(), 0);
    cs_n = 1'b1;
    repeat (2*H) @(negedge clk);
    model_frame(8, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
